// File: rtl/sparc_reg_file_if.sv
// Operand/write/window-control bundle between the pipeline and sparc_reg_file.
// The register file connects to the slave modport; the issuing stage uses the master modport.
interface sparc_reg_file_if #(
  parameter int unsigned NWINDOWS = 4
);
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [31:0]         a;
  logic [31:0]         b;
  logic [4:0]          rd;
  logic [31:0]         wd;
  logic                we;
  logic                save;
  logic                restore;
  logic                wim_we;
  logic [NWINDOWS-1:0] wim_in;
  logic [4:0]          cwp;
  logic [NWINDOWS-1:0] wim;
  logic                win_ovf;
  logic                win_unf;

  modport master (
    output rs1, rs2, rd, wd, we, save, restore, wim_we, wim_in,
    input  a, b, cwp, wim, win_ovf, win_unf
  );

  modport slave (
    input  rs1, rs2, rd, wd, we, save, restore, wim_we, wim_in,
    output a, b, cwp, wim, win_ovf, win_unf
  );
endinterface

// File: rtl/sparc_reg_file.sv
// Windowed SPARC V8 integer register file with CWP/WIM, SAVE/RESTORE and window traps.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data onto the read ports.
module sparc_reg_file #(
  parameter int unsigned NWINDOWS = 4
) (
  input  logic            clk,
  input  logic            reset,
  sparc_reg_file_if.slave bus
);
  localparam int unsigned PHYS_REGS = 8 + 16 * NWINDOWS;
  localparam int unsigned PW        = $clog2(PHYS_REGS);
  localparam int unsigned WW        = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1;
  localparam logic [WW-1:0]       WLAST   = WW'(NWINDOWS - 1);
  localparam logic [NWINDOWS-1:0] WIM_RST = NWINDOWS'(2);

  logic [31:0]         regs [PHYS_REGS];
  logic [WW-1:0]       cwp_q, cwp_d;
  logic [WW-1:0]       dec_c, inc_c, wr_win_c;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_en_c;
  logic [PW-1:0]       wr_idx_c, ra_idx_c, rb_idx_c;

  // Architectural register number + window -> physical index; ins alias the outs of w+1.
  function automatic logic [PW-1:0] map_reg(input logic [4:0] r, input logic [WW-1:0] w);
    int unsigned wn;
    int unsigned idx;
    wn = (w == WLAST) ? 32'd0 : 32'(w) + 32'd1;
    if (r < 5'd8)
      idx = 32'(r);
    else if (r < 5'd24)
      idx = 32'd8 + 32'd16 * 32'(w) + 32'(r) - 32'd8;
    else
      idx = 32'd8 + 32'd16 * wn + 32'(r) - 32'd24;
    return PW'(idx);
  endfunction

  // Window rotation, trap detection and write-window selection (old WIM is checked).
  always_comb begin
    dec_c    = (cwp_q == '0) ? WLAST : cwp_q - WW'(1);
    inc_c    = (cwp_q == WLAST) ? '0 : cwp_q + WW'(1);
    cwp_d    = cwp_q;
    wim_d    = bus.wim_we ? bus.wim_in : wim_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    wr_win_c = cwp_q;
    if (bus.save && !bus.restore) begin
      if (wim_q[dec_c]) begin
        ovf_d = 1'b1;
      end else begin
        cwp_d    = dec_c;
        wr_win_c = dec_c;
      end
    end else if (bus.restore && !bus.save) begin
      if (wim_q[inc_c]) begin
        unf_d = 1'b1;
      end else begin
        cwp_d    = inc_c;
        wr_win_c = inc_c;
      end
    end
    wr_en_c  = bus.we && (bus.rd != 5'd0) && !ovf_d && !unf_d;
    wr_idx_c = map_reg(bus.rd, wr_win_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwp_q <= '0;
      wim_q <= WIM_RST;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      wim_q <= wim_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(PHYS_REGS); i++) regs[i] <= '0;
    end else if (wr_en_c) begin
      regs[wr_idx_c] <= bus.wd;
    end
  end

  // Combinational operand reads in the current window; r0 is hard-wired to zero.
  always_comb begin
    ra_idx_c = map_reg(bus.rs1, cwp_q);
    rb_idx_c = map_reg(bus.rs2, cwp_q);
    bus.a    = (bus.rs1 == 5'd0) ? 32'h0 : regs[ra_idx_c];
    bus.b    = (bus.rs2 == 5'd0) ? 32'h0 : regs[rb_idx_c];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_en_c && (ra_idx_c == wr_idx_c)) bus.a = bus.wd;
    if (wr_en_c && (rb_idx_c == wr_idx_c)) bus.b = bus.wd;
`else
`endif
  end

  assign bus.cwp     = 5'(cwp_q);
  assign bus.wim     = wim_q;
  assign bus.win_ovf = ovf_q;
  assign bus.win_unf = unf_q;
endmodule
